bin2bcd_seq_ctrl: RTL and testbench
===================================

Name: bin2bcd_seq_ctrl

Overview:
Sequential controller for binary-to-BCD conversion using the iterative shift-add-3 (double dabble) algorithm. It replaces the combinational converter with a one-bit-per-cycle datapath plus FSM. Upstream producers hand it a binary word through a valid/ready handshake. The packed-BCD result goes to the display/readout path through a second valid/ready handshake.

Parameters:
BIN_W, 14, binary input width; also the number of shift iterations.
DIGITS, 4, number of BCD output digits; output width is 4*DIGITS.
CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > BIN_W.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
bin  in  BIN_W  binary value; sampled on accept
in_valid  in  1  bin is valid
in_ready  out  1  controller can accept (high only in IDLE)
bcd  out  4*DIGITS  packed BCD result; digit 0 in bits [3:0]
ovf  out  1  input exceeded 10^DIGITS-1 (9999 at defaults)
out_valid  out  1  bcd/ovf are valid
out_ready  in  1  consumer takes result

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset (rst high at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, bcd=0, ovf=0, counter=0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-conversion discards the work in progress; no out_valid follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1. On an edge with in_valid=1, perform the accept:
    - load shift register {bcd_acc=0, bin_acc=bin}
    - ovf_r = (bin > 10^DIGITS-1)
    - cnt=0; go to SHIFT.
- SHIFT:
  - in_ready=0. Each cycle:
    - add 3 to every bcd_acc digit that is >=5;
    - then shift the whole {bcd_acc,bin_acc} left by 1, MSB of bin_acc entering bcd_acc bit 0;
    - cnt++.
  - When cnt==BIN_W-1 at the edge, the final shift is performed and the FSM goes to DONE.
  - The bit shifted out of the top of bcd_acc is discarded, so the lower DIGITS digits remain exact modulo 10^DIGITS.
- DONE:
  - out_valid=1; bcd and ovf are driven from registers, stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid drops and the FSM returns to IDLE.
  - bcd and ovf keep their last values after out_valid drops.
- Latency:
  - Accept at edge N; out_valid high from edge N+BIN_W (14 cycles at defaults).
  - Earliest next accept is the edge after the result is consumed.
  - Throughput is one conversion per BIN_W+2 cycles with out_ready held high.
- in_valid is ignored outside IDLE. bin must not be assumed stable after accept.
- out_ready is ignored outside DONE.
- All outputs are registered; no combinational path from an input to an output.

Optional Feature:
BCD_SATURATE_EN
- Defined: when ovf_r=1, bcd is forced to all-nines (0x9999 at defaults) in DONE. ovf is still asserted.
- Undefined: bcd carries the low DIGITS digits of the true decimal value (modulo 10^DIGITS) with ovf asserted.
- Conversion timing is identical either way.

Test Plan:
- Reset, then bin=4567 with in_valid for 1 cycle -> in_ready low 14 cycles, out_valid at accept+14, bcd=0x4567, ovf=0.
- bin=78, then 67, then 4227, out_ready tied high -> bcd sequence 0x0078, 0x0067, 0x4227, each ovf=0; accepts spaced BIN_W+2 cycles.
- bin=0 and bin=9999 -> bcd=0x0000 and 0x9999, ovf=0.
- bin=16383:
  - without macro -> bcd=0x6383, ovf=1;
  - with BCD_SATURATE_EN -> bcd=0x9999, ovf=1.
- Backpressure:
  - hold out_ready=0 for 20 cycles after out_valid -> bcd, ovf and out_valid stay stable;
  - in_ready stays 0 and in_valid pulses are ignored;
  - raising out_ready for 1 cycle -> return to IDLE.
- Assert rst at SHIFT cycle 5 of converting 1234 -> next cycle in IDLE with out_valid=0 and bcd=0. A fresh conversion of 42 then yields 0x0042.

Source files
------------

// File: rtl/bin2bcd_seq_ctrl.sv
// rtl/bin2bcd_seq_ctrl.sv - Sequential double-dabble binary-to-BCD converter with valid/ready handshakes
// Optional macro BCD_SATURATE_EN: force all-nines BCD output when the input overflows.
module bin2bcd_seq_ctrl #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          SR_W    = BCD_W + BIN_W;
    localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd_acc, bcd_adj, bcd_r;
    logic [BIN_W-1:0]   bin_acc;
    logic [SR_W-1:0]    sr_next;
    logic               ovf_r, ovf_out;
    logic               last;

    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
        // The top bit of bcd_adj falls off here, keeping the result exact modulo 10^DIGITS.
        sr_next = {bcd_adj, bin_acc} << 1;
        last    = (cnt == CNT_W'(BIN_W - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bcd_acc <= '0;
            bin_acc <= '0;
            ovf_r   <= 1'b0;
            bcd_r   <= '0;
            ovf_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bcd_acc <= '0;
                        bin_acc <= bin;
                        ovf_r   <= (32'(bin) > MAX_VAL);
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    bcd_acc <= sr_next[SR_W-1:BIN_W];
                    bin_acc <= sr_next[BIN_W-1:0];
                    cnt     <= cnt + CNT_W'(1);
                    if (last) begin
`ifdef BCD_SATURATE_EN
                        bcd_r <= ovf_r ? {DIGITS{4'h9}} : sr_next[SR_W-1:BIN_W];
`else
                        bcd_r <= sr_next[SR_W-1:BIN_W];
`endif
                        ovf_out <= ovf_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign bcd       = bcd_r;
    assign ovf       = ovf_out;
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// tb/tb_bin2bcd_seq_ctrl.sv - Self-checking bench for bin2bcd_seq_ctrl against an arithmetic decimal model
module tb_bin2bcd_seq_ctrl;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [BIN_W-1:0]  bin;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       bcd;
    logic              ovf;
    logic              out_valid;
    logic              out_ready;

    int npass = 0;
    int ntot  = 0;
    int nfail = 0;

    bin2bcd_seq_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .bin(bin), .in_valid(in_valid), .in_ready(in_ready),
        .bcd(bcd), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_bcd(input int v);
        int r;
        logic [15:0] res;
`ifdef BCD_SATURATE_EN
        if (v > 9999) return 16'h9999;
`endif
        r   = v % 10000;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    task automatic convert(input int v, input int hold);
        int lat;
        int w;
        logic busy_ok;
        w = 0;
        while (!in_ready && w < 50) begin step(); w++; end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        bin = 14'(v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        bin = 14'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            step();
            lat++;
            if (out_valid) break;
        end
        check("in_ready_low_while_busy", 32'(busy_ok), 32'd1);
        check("latency", 32'(lat), 32'(BIN_W));
        check("bcd", 32'(bcd), 32'(model_bcd(v)));
        check("ovf", 32'(ovf), 32'(v > 9999));
        for (int i = 0; i < hold; i++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_after_consume", 32'(out_valid), 32'd0);
        check("bcd_kept_after_consume", 32'(bcd), 32'(model_bcd(v)));
    endtask

    initial begin
        int vals[3];
        int acc_t[3];
        int idx, oidx, cyc;
        logic acc, stable;
        logic [15:0] bcd_h;
        logic ovf_h;

        rst = 1'b1; bin = '0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        convert(4567, 0);
        convert(0, 1);
        convert(9999, 0);
        convert(16383, 2);
        convert(10000, 0);

        // Back-to-back with out_ready held high; accepts must be BIN_W+2 apart.
        vals = '{78, 67, 4227};
        idx = 0; oidx = 0; cyc = 0;
        out_ready = 1'b1; in_valid = 1'b1; bin = 14'(vals[0]);
        while (oidx < 3 && cyc < 200) begin
            acc = in_ready && in_valid;
            step();
            cyc++;
            if (acc) begin
                acc_t[idx] = cyc;
                idx++;
                if (idx < 3) bin = 14'(vals[idx]);
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                check("stream_bcd", 32'(bcd), 32'(model_bcd(vals[oidx])));
                check("stream_ovf", 32'(ovf), 32'd0);
                oidx++;
            end
        end
        check("stream_done", 32'(oidx), 32'd3);
        check("stream_spacing_1", 32'(acc_t[1] - acc_t[0]), 32'(BIN_W + 2));
        check("stream_spacing_2", 32'(acc_t[2] - acc_t[1]), 32'(BIN_W + 2));
        step();
        out_ready = 1'b0;
        check("stream_idle", 32'(in_ready), 32'd1);

        // Backpressure: result must hold while out_ready is low.
        bin = 14'd16383; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin step(); cyc++; end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        bcd_h = bcd; ovf_h = ovf;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom);
            bin = 14'($urandom);
            step();
            if (!out_valid || in_ready || bcd !== bcd_h || ovf !== ovf_h) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_bcd", 32'(bcd_h), 32'(model_bcd(16383)));
        check("bp_ovf", 32'(ovf_h), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a conversion.
        bin = 14'd1234; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) stable = 1'b0;
        end
        check("midrst_no_result", 32'(stable), 32'd1);
        convert(42, 0);

        for (int i = 0; i < 20; i++) begin
            convert(int'($urandom_range(0, 16383)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
